hvac_cmd_tx: RTL and testbench
==============================

HVAC_CMD_TX -- requirements
Module: hvac_cmd_tx

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 50: cycles tx_data is stable before tx_strobe rises.
REQ-002 SHALL have parameter STROBE_CYCLES, default 500: cycles tx_strobe is held high per byte.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 50000: cycles allowed in WAIT_ACK before the attempt fails.
REQ-004 SHALL have parameter MAX_RETRY, default 3: frame re-attempts allowed after the first failed attempt.
REQ-005 SHALL have port CLOCK_50  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port send_req  input  1  one-cycle request to transmit one frame.
REQ-008 SHALL have port set_temp  input  8  set temperature, unsigned degrees.
REQ-009 SHALL have port mode  input  2  HVAC mode: 0=cool, 1=off, 2=heat.
REQ-010 SHALL have port flame  input  1  flame-detected flag.
REQ-011 SHALL have port ack_in  input  1  asynchronous acknowledge from the Arduino.
REQ-012 SHALL have port tx_data  output  8  parallel byte to the Arduino.
REQ-013 SHALL have port tx_strobe  output  1  byte-valid strobe to the Arduino.
REQ-014 SHALL have port busy  output  1  high while a frame is in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse when a frame completes successfully.
REQ-016 SHALL have port error  output  1  one-cycle pulse when a frame is abandoned.
REQ-017 SHALL have port frame_cnt  output  8  count of successful frames.

Function
REQ-018 SHALL pass ack_in through a 2-flop synchronizer; an ack event is a rising edge of the synchronized signal.
REQ-019 SHALL use FSM states IDLE, SETUP, STROBE, WAIT_ACK, FINISH.
REQ-020 SHALL, on send_req in IDLE, latch the inputs and in the next cycle enter SETUP with busy=1 and tx_data=byte0.
REQ-021 SHALL latch set_temp clamped to 99 when it exceeds 99; SHALL latch mode 3 as 1 (off).
REQ-022 SHALL form byte0 = {2'b10, mode[1:0], flame, frame_cnt[2:0]} and byte1 = latched set_temp.
REQ-023 SHALL hold tx_data stable for SETUP_CYCLES in SETUP, then hold tx_strobe=1 for exactly STROBE_CYCLES in STROBE, then enter WAIT_ACK with tx_strobe=0.
REQ-024 SHALL, on an ack event in WAIT_ACK after byte0, load byte1 and return to SETUP.
REQ-025 SHALL, on an ack event in WAIT_ACK after byte1, enter FINISH, pulse done for one cycle, increment frame_cnt (modulo 256, 255 wraps to 0), then return to IDLE.
REQ-026 SHALL ignore ack events outside WAIT_ACK.
REQ-027 SHALL, when ACK_TIMEOUT cycles elapse in WAIT_ACK with no ack event, restart the whole frame from byte0 with the same latched data, consuming one retry.
REQ-028 SHALL, on a timeout with MAX_RETRY retries already consumed, pulse error for one cycle, drive busy=0 and return to IDLE without incrementing frame_cnt.
REQ-029 SHALL give an ack event priority over a timeout that occurs in the same cycle.
REQ-030 SHALL, when send_req arrives while busy, set a single pending flag; further requests while pending SHALL be dropped.
REQ-031 SHALL, on reaching IDLE with pending set, clear pending and start a new frame the following cycle using inputs sampled in that cycle.
REQ-032 SHALL drive tx_data=0 whenever the FSM is in IDLE.

Reset
REQ-033 SHALL, while reset is high, force tx_data=0, tx_strobe=0, busy=0, done=0, error=0, frame_cnt=0, retry count=0, pending=0, synchronizer flops=0, and state=IDLE, including when a frame is in progress.
REQ-034 SHALL NOT generate done or error on exit from reset.

Verification (SETUP=2, STROBE=4, TIMEOUT=20, MAX_RETRY=2)
REQ-035 SHALL verify: send_req with set_temp=22, mode=2, flame=0, and ack returned 3 cycles after each strobe fall -> tx_data 0xA0 then 0x16, each strobe exactly 4 cycles wide, one done pulse, frame_cnt=1.
REQ-036 SHALL verify: set_temp=150, mode=3, flame=1 -> byte0 0x98, byte1 0x63 (99).
REQ-037 SHALL verify: ack withheld -> 3 byte0 attempts, one error pulse, busy=0, frame_cnt unchanged.
REQ-038 SHALL verify: ack withheld for the first attempt only -> second attempt succeeds, one done pulse, no error pulse.
REQ-039 SHALL verify: 3 send_req pulses during an active frame -> exactly 2 frames are sent in total, and the second frame starts 1 cycle after the first returns to IDLE.
REQ-040 SHALL verify: reset asserted mid-STROBE -> all outputs 0 on the next cycle, and a new frame then starts cleanly with frame_cnt[2:0]=0 in byte0.

Source files
------------

// File: rtl/hvac_cmd_tx.sv
`default_nettype none
// =============================================================================
// hvac_cmd_tx : two-byte HVAC command frame sender over a strobe/ack byte link
// Revision    : 1.0
// =============================================================================
module hvac_cmd_tx #(
  parameter int SETUP_CYCLES  = 50,
  parameter int STROBE_CYCLES = 500,
  parameter int ACK_TIMEOUT   = 50000,
  parameter int MAX_RETRY     = 3
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       send_req,
  input  logic [7:0] set_temp,
  input  logic [1:0] mode,
  input  logic       flame,
  input  logic       ack_in,
  output logic [7:0] tx_data,
  output logic       tx_strobe,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] frame_cnt
);

  localparam int MAX_A      = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_CYCLES = (ACK_TIMEOUT > MAX_A) ? ACK_TIMEOUT : MAX_A;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int RETRY_W    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0]   SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STROBE_LAST  = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);
  localparam logic [7:0]         TEMP_MAX     = 8'd99;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    STROBE   = 3'd2,
    WAIT_ACK = 3'd3,
    FINISH   = 3'd4
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] retry;
  logic               second_byte;
  logic               pending;
  logic [7:0]         temp_lat;
  logic [1:0]         mode_lat;
  logic               flame_lat;
  logic               error_q;

  logic ack_meta;
  logic ack_sync;
  logic ack_prev;
  logic ack_event;

  logic cnt_clr;
  logic load;
  logic sel_byte1;
  logic restart;
  logic retry_inc;
  logic frame_inc;
  logic err_set;

  logic [7:0] byte0;

  assign ack_event = ack_sync & ~ack_prev;
  assign byte0     = {2'b10, mode_lat, flame_lat, frame_cnt[2:0]};
  assign error     = error_q;

  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    load       = 1'b0;
    sel_byte1  = 1'b0;
    restart    = 1'b0;
    retry_inc  = 1'b0;
    frame_inc  = 1'b0;
    err_set    = 1'b0;
    tx_data    = 8'h00;
    tx_strobe  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (send_req || pending) begin
          load       = 1'b1;
          cnt_clr    = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        tx_data = second_byte ? temp_lat : byte0;
        if (cnt == SETUP_LAST) begin
          cnt_clr    = 1'b1;
          state_next = STROBE;
        end
      end
      STROBE: begin
        tx_data   = second_byte ? temp_lat : byte0;
        tx_strobe = 1'b1;
        if (cnt == STROBE_LAST) begin
          cnt_clr    = 1'b1;
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        tx_data = second_byte ? temp_lat : byte0;
        // An ack landing on the timeout cycle still counts as delivered.
        if (ack_event) begin
          cnt_clr = 1'b1;
          if (second_byte) begin
            frame_inc  = 1'b1;
            state_next = FINISH;
          end else begin
            sel_byte1  = 1'b1;
            state_next = SETUP;
          end
        end else if (cnt == TIMEOUT_LAST) begin
          cnt_clr = 1'b1;
          if (retry == RETRY_LIMIT) begin
            err_set    = 1'b1;
            state_next = IDLE;
          end else begin
            retry_inc  = 1'b1;
            restart    = 1'b1;
            state_next = SETUP;
          end
        end
      end
      FINISH: begin
        tx_data    = temp_lat;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      retry       <= '0;
      second_byte <= 1'b0;
      pending     <= 1'b0;
      temp_lat    <= 8'h00;
      mode_lat    <= 2'b00;
      flame_lat   <= 1'b0;
      frame_cnt   <= 8'h00;
      error_q     <= 1'b0;
      ack_meta    <= 1'b0;
      ack_sync    <= 1'b0;
      ack_prev    <= 1'b0;
    end else begin
      state    <= state_next;
      error_q  <= err_set;
      ack_meta <= ack_in;
      ack_sync <= ack_meta;
      ack_prev <= ack_sync;

      if (cnt_clr || (state == IDLE)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      if (load) begin
        temp_lat    <= (set_temp > TEMP_MAX) ? TEMP_MAX : set_temp;
        mode_lat    <= (mode == 2'd3) ? 2'd1 : mode;
        flame_lat   <= flame;
        second_byte <= 1'b0;
        retry       <= '0;
      end else begin
        if (sel_byte1) second_byte <= 1'b1;
        if (restart)   second_byte <= 1'b0;
        if (retry_inc) retry       <= retry + RETRY_W'(1);
      end

      if (frame_inc) frame_cnt <= frame_cnt + 8'd1;

      // IDLE always consumes the pending request, so one flag is all we hold.
      if (state == IDLE) begin
        pending <= 1'b0;
      end else if (send_req) begin
        pending <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hvac_cmd_tx.sv
`default_nettype none
// =============================================================================
// tb_hvac_cmd_tx : directed self-checking bench for hvac_cmd_tx
// Revision       : 1.0
// =============================================================================
module tb_hvac_cmd_tx;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       send_req = 1'b0;
  logic [7:0] set_temp = 8'h00;
  logic [1:0] mode     = 2'b00;
  logic       flame    = 1'b0;
  logic       ack_in   = 1'b0;
  logic [7:0] tx_data;
  logic       tx_strobe;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] frame_cnt;

  int checks   = 0;
  int failures = 0;

  // responder / monitor state
  int         ack_mode  = 0;
  int         skip_idx  = -1;
  int         strobes   = 0;
  int         done_cnt  = 0;
  int         err_cnt   = 0;
  int         width     = 0;
  int         ack_cd    = 0;
  int         ack_hold  = 0;
  int         low_run   = 0;
  int         last_gap  = 0;
  logic       strobe_prev = 1'b0;
  logic       busy_prev   = 1'b0;
  logic       ack_this    = 1'b0;
  logic [7:0] first_data  = 8'h00;
  logic [7:0] data_q[$];
  int         width_q[$];

  int s0;
  int d0;
  int e0;
  int k;

  always #10 CLOCK_50 = ~CLOCK_50;

  hvac_cmd_tx #(
    .SETUP_CYCLES (2),
    .STROBE_CYCLES(4),
    .ACK_TIMEOUT  (20),
    .MAX_RETRY    (2)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .send_req (send_req),
    .set_temp (set_temp),
    .mode     (mode),
    .flame    (flame),
    .ack_in   (ack_in),
    .tx_data  (tx_data),
    .tx_strobe(tx_strobe),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .frame_cnt(frame_cnt)
  );

  // Arduino stand-in: acks 3 cycles after each strobe fall, holds ack 3 cycles.
  always @(negedge CLOCK_50) begin
    if (tx_strobe && !strobe_prev) begin
      data_q.push_back(tx_data);
      ack_this = (ack_mode == 1) || ((ack_mode == 2) && (strobes != skip_idx));
      strobes++;
      width = 1;
    end else if (tx_strobe) begin
      width++;
    end
    if (!tx_strobe && strobe_prev) begin
      width_q.push_back(width);
      if (ack_this) ack_cd = 3;
    end else if (ack_cd > 0) begin
      ack_cd--;
      if (ack_cd == 0) begin
        ack_in   = 1'b1;
        ack_hold = 3;
      end
    end else if (ack_hold > 0) begin
      ack_hold--;
      if (ack_hold == 0) ack_in = 1'b0;
    end
    if (done)  done_cnt++;
    if (error) err_cnt++;
    if (busy && !busy_prev) begin
      last_gap   = low_run;
      first_data = tx_data;
    end
    low_run     = busy ? 0 : low_run + 1;
    strobe_prev = tx_strobe;
    busy_prev   = busy;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic kick(input logic [7:0] t, input logic [1:0] m, input logic f);
    @(posedge CLOCK_50);
    #1;
    set_temp = t;
    mode     = m;
    flame    = f;
    send_req = 1'b1;
    @(posedge CLOCK_50);
    #1;
    send_req = 1'b0;
  endtask

  task automatic snap();
    s0 = strobes;
    d0 = done_cnt;
    e0 = err_cnt;
  endtask

  task automatic wait_ends(input int n, input int budget, input string tag);
    int cyc;
    cyc = 0;
    while (((done_cnt + err_cnt) < (d0 + e0 + n)) && (cyc < budget)) begin
      @(negedge CLOCK_50);
      cyc++;
    end
    chk(tag, ((done_cnt + err_cnt) >= (d0 + e0 + n)) ? 1 : 0, 1);
    repeat (3) @(negedge CLOCK_50);
  endtask

  task automatic do_reset();
    @(posedge CLOCK_50);
    #1;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    reset = 1'b0;
    tick(2);

    @(negedge CLOCK_50);
    chk("rst_busy",   busy,      0);
    chk("rst_strobe", tx_strobe, 0);
    chk("rst_data",   tx_data,   0);
    chk("rst_done",   done,      0);
    chk("rst_error",  error,     0);
    chk("rst_fcnt",   frame_cnt, 0);

    // Basic frame: 22 degC heat, no flame
    ack_mode = 1;
    snap();
    kick(8'd22, 2'd2, 1'b0);
    wait_ends(1, 200, "t1_end");
    chk("t1_nstrobe", strobes - s0, 2);
    chk("t1_first",   first_data, 8'hA0);
    chk("t1_b0",      data_q[s0],     8'hA0);
    chk("t1_b1",      data_q[s0 + 1], 8'h16);
    chk("t1_w0",      width_q[s0],     4);
    chk("t1_w1",      width_q[s0 + 1], 4);
    chk("t1_done",    done_cnt - d0, 1);
    chk("t1_err",     err_cnt - e0,  0);
    chk("t1_fcnt",    frame_cnt, 1);
    chk("t1_busy",    busy, 0);
    chk("t1_idle_data", tx_data, 0);

    // Clamping: temp 150 -> 99, mode 3 -> off
    do_reset();
    snap();
    kick(8'd150, 2'd3, 1'b1);
    wait_ends(1, 200, "t2_end");
    chk("t2_b0",   data_q[s0],     8'h98);
    chk("t2_b1",   data_q[s0 + 1], 8'h63);
    chk("t2_fcnt", frame_cnt, 1);

    // Ack withheld: three byte0 attempts then error
    ack_mode = 0;
    snap();
    kick(8'd40, 2'd2, 1'b0);
    wait_ends(1, 300, "t3_end");
    chk("t3_nstrobe", strobes - s0, 3);
    for (int i = 0; i < 3; i++) chk("t3_byte0", data_q[s0 + i], 8'hA1);
    chk("t3_err",  err_cnt - e0,  1);
    chk("t3_done", done_cnt - d0, 0);
    chk("t3_busy", busy, 0);
    chk("t3_fcnt", frame_cnt, 1);

    // First attempt unanswered, retry succeeds
    ack_mode = 2;
    skip_idx = strobes;
    snap();
    kick(8'd30, 2'd0, 1'b1);
    wait_ends(1, 300, "t4_end");
    chk("t4_nstrobe", strobes - s0, 3);
    chk("t4_a0", data_q[s0],     8'h89);
    chk("t4_a1", data_q[s0 + 1], 8'h89);
    chk("t4_a2", data_q[s0 + 2], 8'h1E);
    chk("t4_done", done_cnt - d0, 1);
    chk("t4_err",  err_cnt - e0,  0);
    chk("t4_fcnt", frame_cnt, 2);

    // Three requests while busy collapse into one queued frame
    ack_mode = 1;
    snap();
    kick(8'd25, 2'd0, 1'b0);
    tick(3);
    repeat (3) begin
      kick(8'd25, 2'd0, 1'b0);
      tick(2);
    end
    wait_ends(2, 400, "t5_end");
    repeat (30) @(negedge CLOCK_50);
    chk("t5_done",    done_cnt - d0, 2);
    chk("t5_nstrobe", strobes - s0, 4);
    chk("t5_f1_b0",   data_q[s0],     8'h82);
    chk("t5_f2_b0",   data_q[s0 + 2], 8'h83);
    chk("t5_gap",     last_gap, 1);
    chk("t5_fcnt",    frame_cnt, 4);
    chk("t5_busy",    busy, 0);

    // Reset in the middle of a strobe
    snap();
    kick(8'd22, 2'd2, 1'b0);
    k = 0;
    while (!tx_strobe && (k < 50)) begin
      @(negedge CLOCK_50);
      k++;
    end
    chk("t6_strobe_seen", tx_strobe, 1);
    @(posedge CLOCK_50);
    #1;
    reset = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("t6_data",   tx_data,   0);
    chk("t6_strobe", tx_strobe, 0);
    chk("t6_busy",   busy,      0);
    chk("t6_done",   done,      0);
    chk("t6_error",  error,     0);
    chk("t6_fcnt",   frame_cnt, 0);
    @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    tick(12);
    chk("t6_no_pulse", (done_cnt + err_cnt) - (d0 + e0), 0);
    snap();
    kick(8'd22, 2'd2, 1'b0);
    wait_ends(1, 200, "t6_end");
    chk("t6_b0",   data_q[s0], 8'hA0);
    chk("t6_fcnt", frame_cnt, 1);

    // frame_cnt wrap 255 -> 0
    for (int i = 0; i < 254; i++) begin
      snap();
      kick(8'd22, 2'd2, 1'b0);
      wait_ends(1, 100, "wrap_end");
    end
    chk("wrap_255", frame_cnt, 255);
    snap();
    kick(8'd22, 2'd2, 1'b0);
    wait_ends(1, 100, "wrap_last_end");
    chk("wrap_b0",  data_q[s0], 8'hA7);
    chk("wrap_0",   frame_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
